// File: rtl/seq_det_ctrl.sv
// Programmable serial sequence detector controller: arms on start, counts overlapping
// pattern matches, stops at a target count. Optional bit timeout under SEQ_DET_TIMEOUT_EN.
module seq_det_ctrl #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8,
  parameter int LEN_W   = 4
`ifdef SEQ_DET_TIMEOUT_EN
  ,
  parameter int TO_BITS = 64
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               in,
  input  logic               in_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done
`ifdef SEQ_DET_TIMEOUT_EN
  ,
  output logic               timeout
`endif
);

  localparam int FILL_W = $clog2(MAX_LEN + 1);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HUNT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]         state_r;
  logic [MAX_LEN-1:0] pat_r;
  logic [LEN_W-1:0]   len_r;
  logic [CNT_W-1:0]   tgt_r;
  logic [MAX_LEN-1:0] hist_r;
  logic [FILL_W-1:0]  fill_r;

  logic [MAX_LEN-1:0] hist_nxt_s;
  logic [FILL_W-1:0]  fill_nxt_s;
  logic [MAX_LEN-1:0] mask_s;
  logic [LEN_W-1:0]   len_cfg_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               hit_s;
  logic               tgt_hit_s;

`ifdef SEQ_DET_TIMEOUT_EN
  localparam int TO_W = $clog2(TO_BITS + 1);
  logic [TO_W-1:0] to_cnt_r;
  logic [TO_W-1:0] to_nxt_s;
  logic            to_fire_s;
`endif

  // Next history/fill, clamped length and the match/target decisions for this edge
  always_comb begin
    hist_nxt_s = {hist_r[MAX_LEN-2:0], in};
    if (fill_r == FILL_W'(MAX_LEN)) begin
      fill_nxt_s = fill_r;
    end else begin
      fill_nxt_s = fill_r + FILL_W'(1);
    end
    for (int i = 0; i < MAX_LEN; i++) begin
      mask_s[i] = (i < int'(len_r));
    end
    if (cfg_len == {LEN_W{1'b0}}) begin
      len_cfg_s = LEN_W'(1);
    end else if (int'(cfg_len) > MAX_LEN) begin
      len_cfg_s = LEN_W'(MAX_LEN);
    end else begin
      len_cfg_s = cfg_len;
    end
    if (match_cnt == {CNT_W{1'b1}}) begin
      cnt_inc_s = match_cnt;
    end else begin
      cnt_inc_s = match_cnt + CNT_W'(1);
    end
    // fill guard keeps the cleared history from matching all-zero patterns early
    hit_s = (state_r == ST_HUNT) && in_valid &&
            ((hist_nxt_s & mask_s) == (pat_r & mask_s)) &&
            (int'(fill_nxt_s) >= int'(len_r));
    tgt_hit_s = (tgt_r != {CNT_W{1'b0}}) && (cnt_inc_s == tgt_r);
`ifdef SEQ_DET_TIMEOUT_EN
    to_nxt_s  = to_cnt_r + TO_W'(1);
    to_fire_s = (state_r == ST_HUNT) && in_valid && !hit_s && (to_nxt_s == TO_W'(TO_BITS));
`endif
  end

  // Controller state, configuration, history and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      pat_r     <= {MAX_LEN{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      tgt_r     <= {CNT_W{1'b0}};
      hist_r    <= {MAX_LEN{1'b0}};
      fill_r    <= {FILL_W{1'b0}};
      match     <= 1'b0;
      match_cnt <= {CNT_W{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
      to_cnt_r  <= {TO_W{1'b0}};
      timeout   <= 1'b0;
`endif
    end else begin
      match <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (abort) begin
            state_r <= ST_IDLE;
          end else if (start) begin
            state_r   <= ST_HUNT;
            hist_r    <= {MAX_LEN{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            match_cnt <= {CNT_W{1'b0}};
            busy      <= 1'b1;
            done      <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
            to_cnt_r  <= {TO_W{1'b0}};
            timeout   <= 1'b0;
`endif
          end else if (cfg_we) begin
            pat_r <= cfg_pat;
            len_r <= len_cfg_s;
            tgt_r <= cfg_target;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HUNT: begin
          if (abort) begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end else if (in_valid) begin
            hist_r <= hist_nxt_s;
            fill_r <= fill_nxt_s;
            if (hit_s) begin
              match     <= 1'b1;
              match_cnt <= cnt_inc_s;
`ifdef SEQ_DET_TIMEOUT_EN
              to_cnt_r  <= {TO_W{1'b0}};
`endif
              if (tgt_hit_s) begin
                state_r <= ST_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                state_r <= ST_HUNT;
              end
            end else begin
`ifdef SEQ_DET_TIMEOUT_EN
              to_cnt_r <= to_nxt_s;
              if (to_fire_s) begin
                state_r <= ST_DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                timeout <= 1'b1;
              end else begin
                state_r <= ST_HUNT;
              end
`else
              state_r <= ST_HUNT;
`endif
            end
          end else begin
            state_r <= ST_HUNT;
          end
        end
        ST_DONE: begin
          if (abort) begin
            state_r <= ST_IDLE;
            done    <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end else if (start) begin
            state_r   <= ST_HUNT;
            hist_r    <= {MAX_LEN{1'b0}};
            fill_r    <= {FILL_W{1'b0}};
            match_cnt <= {CNT_W{1'b0}};
            busy      <= 1'b1;
            done      <= 1'b0;
`ifdef SEQ_DET_TIMEOUT_EN
            to_cnt_r  <= {TO_W{1'b0}};
            timeout   <= 1'b0;
`endif
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_det_ctrl.sv
// Self-checking bench for seq_det_ctrl: directed scenarios plus randomized runs
// against a queue-based reference model of the detector rules.
module tb_seq_det_ctrl;

  localparam int TO_BITS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pat = 8'd0;
  logic [3:0] cfg_len = 4'd0;
  logic [7:0] cfg_target = 8'd0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in = 1'b0;
  logic       in_valid = 1'b0;
  logic       match;
  logic [7:0] match_cnt;
  logic       busy;
  logic       done;
`ifdef SEQ_DET_TIMEOUT_EN
  logic       timeout;
`endif

  int vecs = 0;
  int errs = 0;

  // reference model: mode 0=idle 1=hunting 2=finished
  int         m_mode;
  bit [7:0]   m_pat;
  int         m_len;
  int         m_tgt;
  bit         hq[$];
  int         m_cnt;
  bit         m_match;
  bit         m_tmo;
  int         m_to;

`ifdef SEQ_DET_TIMEOUT_EN
  seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8), .LEN_W(4), .TO_BITS(TO_BITS)) dut (
`else
  seq_det_ctrl #(.MAX_LEN(8), .CNT_W(8), .LEN_W(4)) dut (
`endif
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
    .cfg_target(cfg_target), .start(start), .abort(abort), .in(in), .in_valid(in_valid),
    .match(match), .match_cnt(match_cnt), .busy(busy), .done(done)
`ifdef SEQ_DET_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_pat = 8'd0; m_len = 0; m_tgt = 0; hq.delete();
    m_cnt = 0; m_match = 1'b0; m_tmo = 1'b0; m_to = 0;
  endtask

  task automatic model_fresh();
    m_mode = 1; hq.delete(); m_cnt = 0; m_to = 0; m_tmo = 1'b0;
  endtask

  function automatic logic [10:0] exp_vec();
    return {m_match, 8'(m_cnt), (m_mode == 1), (m_mode == 2)};
  endfunction

  // drive one clock of inputs, advance the model, then sample 1 time unit after the edge
  task automatic step(input bit w, input bit [7:0] p, input bit [3:0] l, input bit [7:0] t,
                      input bit s, input bit a, input bit v, input bit b);
    bit hit;
    cfg_we = w; cfg_pat = p; cfg_len = l; cfg_target = t;
    start = s; abort = a; in_valid = v; in = b;
    m_match = 1'b0;
    case (m_mode)
      0: begin
        if (!a && s) model_fresh();
        else if (!a && w) begin
          m_pat = p;
          m_len = (l == 4'd0) ? 1 : ((int'(l) > 8) ? 8 : int'(l));
          m_tgt = int'(t);
        end
      end
      1: begin
        if (a) m_mode = 0;
        else if (v) begin
          hq.push_back(b);
          if (hq.size() > 16) void'(hq.pop_front());
          hit = (hq.size() >= m_len);
          if (hit) begin
            for (int k = 0; k < m_len; k++)
              if (m_pat[k] != hq[hq.size() - 1 - k]) hit = 1'b0;
          end
          if (hit) begin
            m_match = 1'b1;
            if (m_cnt < 255) m_cnt++;
            m_to = 0;
            if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
          end else begin
`ifdef SEQ_DET_TIMEOUT_EN
            m_to++;
            if (m_to == TO_BITS) begin m_mode = 2; m_tmo = 1'b1; end
`endif
          end
        end
      end
      default: begin
        if (a) begin m_mode = 0; m_tmo = 1'b0; end
        else if (s) model_fresh();
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input bit [7:0] p, input bit [3:0] l, input bit [7:0] t);
    step(1'b1, p, l, t, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic do_start();  step(1'b0, 8'd0, 4'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_abort();  step(1'b0, 8'd0, 4'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_bit(input bit b); step(1'b0, 8'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b1, b); endtask
  task automatic do_idle();   step(1'b0, 8'd0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0); endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    vecs++;
    if ({match, match_cnt, busy, done} !== 11'd0) begin
      errs++; $display("FAIL reset_init: got %b want %b", {match, match_cnt, busy, done}, 11'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_cfg(8'h01, 4'd1, 8'd0);
    do_start();
    do_bit(1'b1);
    do_bit(1'b1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vecs++;
    if ({match, match_cnt, busy, done} !== 11'd0) begin
      errs++; $display("FAIL reset_midrun: got %b want %b", {match, match_cnt, busy, done}, 11'd0);
    end
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_target();
    bit [6:0] stream;
    stream = 7'b0110111;
    do_cfg(8'b11, 4'd2, 8'd3);
    do_start();
    for (int i = 6; i >= 0; i--) begin
      do_bit(stream[i]);
      vecs++;
      if ({match, match_cnt, busy, done} !== exp_vec()) begin
        errs++; $display("FAIL target bit%0d: got %b want %b", 7 - i, {match, match_cnt, busy, done}, exp_vec());
      end
    end
    vecs++;
    if (match !== 1'b1 || match_cnt !== 8'd3 || done !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL target_end: got m=%b cnt=%0d d=%b b=%b want 1 3 1 0", match, match_cnt, done, busy);
    end
    do_abort();
  endtask

  task automatic test_overlap();
    bit [6:0] stream;
    stream = 7'b1011011;
    do_cfg(8'b1011, 4'd4, 8'd0);
    do_start();
    for (int i = 6; i >= 0; i--) begin
      do_bit(stream[i]);
      vecs++;
      if ({match, match_cnt, busy, done} !== exp_vec()) begin
        errs++; $display("FAIL overlap bit%0d: got %b want %b", 7 - i, {match, match_cnt, busy, done}, exp_vec());
      end
    end
    do_abort();
    vecs++;
    if (match_cnt !== 8'd2 || busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL overlap_abort: got cnt=%0d b=%b d=%b want 2 0 0", match_cnt, busy, done);
    end
  endtask

  task automatic test_fill_guard();
    do_cfg(8'b00, 4'd2, 8'd0);
    do_start();
    do_bit(1'b0);
    vecs++;
    if (match !== 1'b0) begin
      errs++; $display("FAIL fill_first: got %b want 0", match);
    end
    for (int g = 0; g < 3; g++) do_idle();
    do_bit(1'b0);
    vecs++;
    if (match !== 1'b1 || match_cnt !== 8'd1) begin
      errs++; $display("FAIL fill_second: got m=%b cnt=%0d want 1 1", match, match_cnt);
    end
    do_abort();
  endtask

  task automatic test_config();
    bit [7:0] pat;
    bit [3:0] b4;
    pat = 8'hA5;
    b4 = 4'b1011;
    do_cfg(8'h01, 4'd0, 8'd0);
    do_start();
    for (int i = 3; i >= 0; i--) begin
      do_bit(b4[i]);
      vecs++;
      if ({match, match_cnt, busy, done} !== exp_vec()) begin
        errs++; $display("FAIL len0 bit%0d: got %b want %b", 3 - i, {match, match_cnt, busy, done}, exp_vec());
      end
    end
    do_abort();
    do_cfg(pat, 4'd15, 8'd0);
    do_start();
    for (int i = 7; i >= 0; i--) do_bit(pat[i]);
    vecs++;
    if (match !== 1'b1 || match_cnt !== 8'd1) begin
      errs++; $display("FAIL len15: got m=%b cnt=%0d want 1 1", match, match_cnt);
    end
    step(1'b1, 8'h00, 4'd1, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_bit(1'b0);
    vecs++;
    if (match !== 1'b0 || busy !== 1'b1 || {match, match_cnt, busy, done} !== exp_vec()) begin
      errs++; $display("FAIL cfg_in_hunt: got %b want %b", {match, match_cnt, busy, done}, exp_vec());
    end
    do_abort();
    step(1'b0, 8'd0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errs++; $display("FAIL start_abort: got b=%b d=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    do_cfg(8'h01, 4'd1, 8'd2);
    for (int r = 0; r < 2; r++) begin
      do_start();
      do_bit(1'b1);
      do_bit(1'b1);
      vecs++;
      if (done !== 1'b1 || match_cnt !== 8'd2 || match !== 1'b1) begin
        errs++; $display("FAIL b2b_run%0d: got d=%b cnt=%0d m=%b want 1 2 1", r, done, match_cnt, match);
      end
    end
    do_bit(1'b1);
    vecs++;
    if ({match, match_cnt, busy, done} !== exp_vec() || match_cnt !== 8'd2) begin
      errs++; $display("FAIL done_hold: got %b want %b", {match, match_cnt, busy, done}, exp_vec());
    end
    do_abort();
    vecs++;
    if (done !== 1'b0 || match_cnt !== 8'd2) begin
      errs++; $display("FAIL done_abort: got d=%b cnt=%0d want 0 2", done, match_cnt);
    end
  endtask

  task automatic test_random();
    for (int run = 0; run < 25; run++) begin
      do_cfg(8'($urandom), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 4)));
      do_start();
      for (int c = 0; c < 60; c++) begin
        step(($urandom_range(0, 19) == 0), 8'($urandom), 4'($urandom_range(0, 15)), 8'($urandom_range(0, 4)),
             ($urandom_range(0, 49) == 0), ($urandom_range(0, 79) == 0),
             ($urandom_range(0, 3) != 0), 1'($urandom));
        vecs++;
        if ({match, match_cnt, busy, done} !== exp_vec()) begin
          errs++; $display("FAIL random r%0d c%0d: got %b want %b", run, c, {match, match_cnt, busy, done}, exp_vec());
        end
`ifdef SEQ_DET_TIMEOUT_EN
        vecs++;
        if (timeout !== m_tmo) begin
          errs++; $display("FAIL random_tmo r%0d c%0d: got %b want %b", run, c, timeout, m_tmo);
        end
`endif
      end
      do_abort();
    end
  endtask

`ifdef SEQ_DET_TIMEOUT_EN
  task automatic test_timeout();
    do_cfg(8'b11, 4'd2, 8'd0);
    do_start();
    for (int i = 0; i < 4; i++) do_bit(1'b0);
    vecs++;
    if (timeout !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
      errs++; $display("FAIL timeout_fire: got t=%b d=%b b=%b want 1 1 0", timeout, done, busy);
    end
    do_start();
    vecs++;
    if (timeout !== 1'b0 || busy !== 1'b1) begin
      errs++; $display("FAIL timeout_clear: got t=%b b=%b want 0 1", timeout, busy);
    end
    do_abort();
  endtask
`endif

  initial begin
    test_reset();
    test_target();
    test_overlap();
    test_fill_guard();
    test_config();
    test_back_to_back();
`ifdef SEQ_DET_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
